dm_cache_controller: RTL and testbench

- Read-side controller for the direct-mapped cache data/tag array: 256 lines, 16 words per line, 32-bit words, 20-bit tag.
- Accepts CPU word-read requests and drives the array's lookup port, then compares tags.
- On a miss, it fetches the 16-word line from main memory as an in-order burst, writes the whole line into the array and returns the requested word.
- It owns the per-line valid bits, because the array has no reset.

---
 rtl/dm_cache_controller.sv | 143 ++++++++++++++
 tb/tb_dm_cache_controller.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_controller.sv
// Read-side controller for a direct-mapped cache: tag lookup, line fill from memory on miss,
// per-line valid bits (the array itself has no reset) and saturating hit/miss counters.
module dm_cache_controller #(
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 16,
    parameter int INDEX_W    = 8,
    parameter int TAG_W      = 20,
    parameter int CNT_W      = 32
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         cpu_req_valid,
    output logic                                         cpu_req_ready,
    input  logic [TAG_W+INDEX_W+$clog2(LINE_WORDS)-1:0]  cpu_addr,
    output logic                                         cpu_resp_valid,
    output logic [WORD_W-1:0]                            cpu_rdata,
    output logic                                         cache_mode,
    output logic [INDEX_W-1:0]                           cache_index,
    output logic [$clog2(LINE_WORDS)-1:0]                cache_blkoffset,
    output logic [TAG_W-1:0]                             cache_tagin,
    output logic [LINE_WORDS*WORD_W-1:0]                 cache_datain,
    input  logic [WORD_W-1:0]                            cache_dataout,
    input  logic [TAG_W-1:0]                             cache_tagout,
    input  logic                                         cache_valid,
    output logic                                         mem_req_valid,
    input  logic                                         mem_req_ready,
    output logic [TAG_W+INDEX_W+$clog2(LINE_WORDS)-1:0]  mem_addr,
    input  logic                                         mem_rvalid,
    input  logic [WORD_W-1:0]                            mem_rdata,
    output logic [CNT_W-1:0]                             hit_count,
    output logic [CNT_W-1:0]                             miss_count
);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int ADDR_W = TAG_W + INDEX_W + OFF_W;
    localparam int LINES  = 1 << INDEX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        COMPARE,
        MISS_REQ,
        MISS_FILL,
        WRITE
    } state_t;

    state_t                              state;
    logic [ADDR_W-1:0]                   req_addr;
    logic [LINES-1:0]                    line_valid;
    logic [OFF_W-1:0]                    beat;
    logic [LINE_WORDS-1:0][WORD_W-1:0]   line_buf;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [OFF_W-1:0]   req_off;
    logic               hit;

    assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
    assign req_index = req_addr[OFF_W +: INDEX_W];
    assign req_off   = req_addr[OFF_W-1:0];

    // The array always looks at the captured request; tag and line are only consumed while cache_mode=1.
    assign cache_index     = req_index;
    assign cache_blkoffset = req_off;
    assign cache_tagin     = req_tag;
    assign cache_datain    = line_buf;

    assign hit = line_valid[req_index] & cache_valid & (cache_tagout == req_tag);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            req_addr       <= '0;
            line_valid     <= '0;
            beat           <= '0;
            line_buf       <= '0;
            cpu_req_ready  <= 1'b1;
            cpu_resp_valid <= 1'b0;
            cpu_rdata      <= '0;
            cache_mode     <= 1'b0;
            mem_req_valid  <= 1'b0;
            mem_addr       <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
        end else begin
            cpu_resp_valid <= 1'b0;
            cache_mode     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req_valid && cpu_req_ready) begin
                        req_addr      <= cpu_addr;
                        cpu_req_ready <= 1'b0;
                        state         <= LOOKUP;
                    end
                end
                LOOKUP: state <= COMPARE;
                COMPARE: begin
                    if (hit) begin
                        cpu_rdata      <= cache_dataout;
                        cpu_resp_valid <= 1'b1;
                        hit_count      <= sat_inc(hit_count);
                        cpu_req_ready  <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        miss_count    <= sat_inc(miss_count);
                        mem_req_valid <= 1'b1;
                        mem_addr      <= {req_tag, req_index, {OFF_W{1'b0}}};
                        state         <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        beat          <= '0;
                        state         <= MISS_FILL;
                    end
                end
                MISS_FILL: begin
                    if (mem_rvalid) begin
                        line_buf[beat] <= mem_rdata;
                        beat           <= beat + 1'b1;
                        if (beat == OFF_W'(LINE_WORDS - 1)) begin
                            cache_mode <= 1'b1;
                            state      <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    line_valid[req_index] <= 1'b1;
                    cpu_rdata             <= line_buf[req_off];
                    cpu_resp_valid        <= 1'b1;
                    cpu_req_ready         <= 1'b1;
                    state                 <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_cache_controller.sv
// Randomized bench for dm_cache_controller: behavioural array and burst memory, plus a
// line-level reference of which lines the cache should hold and what each read returns.
module tb_dm_cache_controller;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_req_valid = 1'b0;
    logic         cpu_req_ready;
    logic [31:0]  cpu_addr = '0;
    logic         cpu_resp_valid;
    logic [31:0]  cpu_rdata;
    logic         cache_mode;
    logic [7:0]   cache_index;
    logic [3:0]   cache_blkoffset;
    logic [19:0]  cache_tagin;
    logic [511:0] cache_datain;
    logic [31:0]  cache_dataout = '0;
    logic [19:0]  cache_tagout = '0;
    logic         cache_valid = 1'b0;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_addr;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    dm_cache_controller dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_addr(cpu_addr),
        .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
        .cache_mode(cache_mode), .cache_index(cache_index), .cache_blkoffset(cache_blkoffset),
        .cache_tagin(cache_tagin), .cache_datain(cache_datain),
        .cache_dataout(cache_dataout), .cache_tagout(cache_tagout), .cache_valid(cache_valid),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Main memory contents; line 0x123 holds 0xA0..0xAF so the directed reads have known data.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h0000123) return 32'hA0 + {28'h0, a[3:0]};
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Cache array: no reset, unwritten lines report tag 0 with valid set and junk data.
    bit          arr_w [256];
    logic [19:0] arr_tag [256];
    logic [31:0] arr_data [256][16];

    always @(posedge clk) begin
        if (arr_w[cache_index]) begin
            cache_tagout  <= arr_tag[cache_index];
            cache_dataout <= arr_data[cache_index][cache_blkoffset];
        end else begin
            cache_tagout  <= '0;
            cache_dataout <= 32'hDEAD_BEEF;
        end
        cache_valid <= 1'b1;
        if (cache_mode) begin
            arr_w[cache_index]   <= 1'b1;
            arr_tag[cache_index] <= cache_tagin;
            for (int w = 0; w < 16; w++) arr_data[cache_index][w] <= cache_datain[w*32 +: 32];
        end
    end

    // Activity monitor
    int          cyc = 0;
    int          rsp_cnt = 0;
    int          wr_cnt = 0;
    int          mreq_cyc = 0;
    int          last_wr_cyc = 0;
    logic [7:0]  last_wr_idx = '0;
    logic [19:0] last_wr_tag = '0;
    logic [511:0] last_wr_line = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cpu_resp_valid) rsp_cnt <= rsp_cnt + 1;
        if (mem_req_valid) mreq_cyc <= mreq_cyc + 1;
        if (cache_mode) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_cyc  <= cyc;
            last_wr_idx  <= cache_index;
            last_wr_tag  <= cache_tagin;
            last_wr_line <= cache_datain;
        end
    end

    // Burst memory: optional request backpressure, directed and random beat gaps, aborts on reset.
    int          cfg_ready_wait = 0;
    int          cfg_gap_pct = 0;
    logic [15:0] cfg_gap_mask = '0;
    int          bfm_beats = 0;
    logic [31:0] bfm_last_addr = '0;

    initial begin : mem_bfm
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req_valid) begin : burst
                logic [31:0] base;
                int          w;
                bit          ab;
                base = mem_addr;
                bfm_last_addr = mem_addr;
                bfm_beats = 0;
                ab = 1'b0;
                w = cfg_ready_wait;
                while (w > 0 && !ab) begin
                    @(negedge clk);
                    if (!rst_n) ab = 1'b1;
                    else begin
                        chk_eq("memreq_held", mem_req_valid, 1);
                        chk_eq("memaddr_stable", mem_addr, base);
                    end
                    w--;
                end
                if (!ab) begin
                    mem_req_ready = 1'b1;
                    @(negedge clk);
                    mem_req_ready = 1'b0;
                    if (!rst_n) ab = 1'b1;
                end
                for (int b = 0; b < 16 && !ab; b++) begin
                    if (cfg_gap_mask[b] || ($urandom_range(99) < cfg_gap_pct)) begin
                        mem_rvalid = 1'b0;
                        @(negedge clk);
                        if (!rst_n) ab = 1'b1;
                    end
                    if (!ab) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = mem_word(base + b);
                        bfm_beats++;
                        @(negedge clk);
                        mem_rvalid = 1'b0;
                        if (!rst_n) ab = 1'b1;
                    end
                end
                mem_rvalid = 1'b0;
            end
        end
    end

    // Reference: which line each index holds, and the counters.
    bit          ref_v [256];
    logic [19:0] ref_tag [256];
    logic [31:0] ref_hits = '0;
    logic [31:0] ref_misses = '0;

    function automatic logic [31:0] ref_sat(input logic [31:0] v);
        if (v != 32'hFFFF_FFFF) v++;
        return v;
    endfunction

    task automatic start_req(input logic [31:0] addr);
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_addr      = addr;
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr);
        logic [19:0] tg;
        logic [7:0]  ix;
        bit          exp_hit;
        logic [31:0] exp_d;
        int          lat, wr0, req0, rsp0;
        tg = addr[31:12];
        ix = addr[11:4];
        exp_hit = ref_v[ix] && (ref_tag[ix] == tg);
        exp_d = mem_word(addr);
        @(negedge clk);
        chk_eq("req_ready_idle", cpu_req_ready, 1);
        wr0 = wr_cnt; req0 = mreq_cyc; rsp0 = rsp_cnt;
        cpu_req_valid = 1'b1;
        cpu_addr      = addr;
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
        chk_eq("req_ready_busy", cpu_req_ready, 0);
        lat = 1;
        while (!cpu_resp_valid && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk_eq("resp_seen", cpu_resp_valid, 1);
        chk_eq("rdata", cpu_rdata, exp_d);
        if (exp_hit) begin
            chk_eq("hit_latency", lat, 3);
            chk_eq("hit_no_memreq", mreq_cyc - req0, 0);
            chk_eq("hit_no_write", wr_cnt - wr0, 0);
            ref_hits = ref_sat(ref_hits);
        end else begin
            chk_eq("miss_one_write", wr_cnt - wr0, 1);
            chk_eq("miss_wr_index", last_wr_idx, ix);
            chk_eq("miss_wr_tag", last_wr_tag, tg);
            chk_eq("miss_mem_addr", bfm_last_addr, {addr[31:4], 4'h0});
            chk_eq("miss_resp_after_write", cyc - last_wr_cyc, 1);
            for (int w = 0; w < 16; w++)
                chk_eq("fill_word", last_wr_line[w*32 +: 32], mem_word({addr[31:4], w[3:0]}));
            ref_misses = ref_sat(ref_misses);
            ref_v[ix]   = 1'b1;
            ref_tag[ix] = tg;
        end
        chk_eq("hit_count", hit_count, ref_hits);
        chk_eq("miss_count", miss_count, ref_misses);
        @(posedge clk);
        #1;
        chk_eq("resp_single_pulse", cpu_resp_valid, 0);
        chk_eq("rdata_hold", cpu_rdata, exp_d);
        chk_eq("resp_once", rsp_cnt - rsp0, 1);
    endtask

    task automatic reset_mid();
        int wr0, rsp0;
        wr0 = wr_cnt; rsp0 = rsp_cnt;
        rst_n = 1'b0;
        #1;
        chk_eq("rst_memreq", mem_req_valid, 0);
        chk_eq("rst_ready", cpu_req_ready, 1);
        chk_eq("rst_resp", cpu_resp_valid, 0);
        chk_eq("rst_rdata", cpu_rdata, 0);
        chk_eq("rst_mode", cache_mode, 0);
        chk_eq("rst_index", cache_index, 0);
        chk_eq("rst_offset", cache_blkoffset, 0);
        chk_eq("rst_tagin", cache_tagin, 0);
        chk_eq("rst_datain_zero", cache_datain == '0, 1);
        chk_eq("rst_memaddr", mem_addr, 0);
        chk_eq("rst_hits", hit_count, 0);
        chk_eq("rst_misses", miss_count, 0);
        for (int i = 0; i < 256; i++) ref_v[i] = 1'b0;
        ref_hits = '0;
        ref_misses = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk_eq("rst_no_write", wr_cnt - wr0, 0);
        chk_eq("rst_no_resp", rsp_cnt - rsp0, 0);
        chk_eq("rst_idle_memreq", mem_req_valid, 0);
        chk_eq("rst_idle_ready", cpu_req_ready, 1);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        logic [31:0] a;
        logic [7:0]  idx_pool [4];
        idx_pool[0] = 8'h23; idx_pool[1] = 8'h05; idx_pool[2] = 8'h06; idx_pool[3] = 8'hF1;

        repeat (2) @(negedge clk);
        reset_mid();

        // Cold miss, then hit on the same line
        do_read(32'h0000_1234);
        do_read(32'h0000_1239);

        // Conflict on index 0x23
        do_read(32'h0000_2230);
        do_read(32'h0000_1230);

        // Request backpressure and beat gaps after beats 3 and 10
        cfg_ready_wait = 5;
        cfg_gap_mask   = 16'h0810;
        do_read(32'h0004_5678);
        cfg_ready_wait = 0;
        cfg_gap_mask   = '0;

        // Reset while the line request is pending
        cfg_ready_wait = 20;
        start_req(32'h0007_7770);
        n = 0;
        while (!mem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk_eq("memreq_before_reset", mem_req_valid, 1);
        @(posedge clk);
        #2;
        reset_mid();
        cfg_ready_wait = 0;

        // Reset in the middle of a fill, after beat 7
        do_read(32'h0000_1234);
        do_read(32'h0000_1239);
        bfm_beats = 0;
        start_req(32'h0009_9990);
        n = 0;
        while (bfm_beats < 8 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk_eq("beat7_reached", bfm_beats >= 8, 1);
        @(posedge clk);
        #2;
        reset_mid();
        do_read(32'h0000_1239);
        do_read(32'h0009_9990);

        // Hit counter saturation
        @(negedge clk);
        force dut.hit_count = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.hit_count;
        ref_hits = 32'hFFFF_FFFE;
        @(negedge clk);
        chk_eq("hit_preload", hit_count, 32'hFFFF_FFFE);
        do_read(32'h0000_1239);
        do_read(32'h0000_1230);
        do_read(32'h0000_123F);

        // Random traffic over a few conflicting indices and tags
        for (int i = 0; i < 150; i++) begin
            cfg_ready_wait = $urandom_range(3);
            cfg_gap_pct    = 25;
            a = {12'h000, 8'($urandom_range(5)), idx_pool[$urandom_range(3)], 4'($urandom_range(15))};
            do_read(a);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
